bus_interface_mf: RTL and testbench

Second-generation ICE bus endpoint. It replaces the fixed-address, pass-through receive path with a parametrised one:
- masked address matching;
- a buffered, frame-committed input FIFO;
- overflow handling, with drop or truncate selected by parameter;
- automatic NAK generation for overflowed frames.
It sits between the master-bus broadcast, the slave-bus arbiter and one local function block. Local blocks use a ready/valid stream, not addressed reads.

---
 rtl/bus_interface_mf.sv | 257 +++++++++++++++++++++++++
 tb/tb_bus_interface_mf.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interface_mf.sv
// ============================================================================
// bus_interface_mf: ICE bus endpoint with masked address match, frame-committed FIFOs, NAK injection
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_interface_mf #(
   parameter logic [7:0] ADDR             = 8'h00,
   parameter logic [7:0] ADDR_MASK        = 8'hFF,
   parameter int         IN_DEPTH_LOG2    = 9,
   parameter int         OUT_DEPTH_LOG2   = 9,
   parameter bit         DROP_ON_OVERFLOW = 1'b1,
   parameter bit         NAK_ENABLE       = 1'b1,
   parameter logic [7:0] NAK_CODE         = 8'h15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] ma_data,
   input  logic [7:0] ma_addr,
   input  logic       ma_data_valid,
   input  logic       ma_frame_valid,
   inout  wire        sl_overflow,
   inout  wire  [8:0] sl_data,
   output logic       sl_arb_request,
   input  logic       sl_arb_grant,
   input  logic       sl_data_next,
   output logic [8:0] in_frame_data,
   output logic       in_frame_data_valid,
   input  logic       in_frame_data_ready,
   input  logic [7:0] out_frame_data,
   input  logic       out_frame_data_latch,
   input  logic       out_frame_valid,
   output logic       out_overflow
);

   localparam int IN_DEPTH  = 1 << IN_DEPTH_LOG2;
   localparam int OUT_DEPTH = 1 << OUT_DEPTH_LOG2;
   localparam int IPW       = IN_DEPTH_LOG2 + 1;
   localparam int OPW       = OUT_DEPTH_LOG2 + 1;
   // A data byte must leave two free entries behind it; NAK needs two entries outright.
   localparam logic [IPW-1:0] IN_LIM  = IPW'(IN_DEPTH - 2);
   localparam logic [OPW-1:0] OUT_LIM = OPW'(OUT_DEPTH - 2);
   localparam logic [OPW-1:0] NAK_LIM = OPW'(OUT_DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_NAK_DATA = 2'd1,
      S_NAK_EOF  = 2'd2
   } nak_state_e;

   logic [8:0]     in_mem_q  [IN_DEPTH];
   logic [8:0]     out_mem_q [OUT_DEPTH];

   logic [IPW-1:0] wp_q, wp_d, cp_q, cp_d, rp_q, rp_d;
   logic [OPW-1:0] wp_o_q, wp_o_d, cp_o_q, cp_o_d, rp_o_q, rp_o_d;
   logic           m_fv_q, ovf_q, ovf_d, in_wrote_q, in_wrote_d;
   logic           in_vld_q, in_vld_d;
   logic [8:0]     in_data_q, in_data_d;
   logic           out_fv_q, out_wrote_q, out_wrote_d, out_drop_q, out_drop_d;
   logic           out_ovf_q, out_ovf_d, nak_q, nak_d, req_q, req_d;
   nak_state_e     state_q, state_d;

   logic           in_we, out_we;
   logic [8:0]     in_wdata, out_wdata;
   logic           w_nak_set;

   wire            w_match    = ((ma_addr & ADDR_MASK) == (ADDR & ADDR_MASK));
   wire            w_m_fv     = ma_frame_valid & w_match;
   wire            w_in_byte  = w_m_fv & ma_data_valid;
   wire            w_in_end   = m_fv_q & ~w_m_fv;
   wire [IPW-1:0]  w_in_used  = wp_q - rp_q;
   wire            w_in_room  = (w_in_used < IN_LIM);

   wire            w_ob       = out_frame_data_latch & out_frame_valid;
   wire            w_o_end    = out_fv_q & ~out_frame_valid;
   wire            w_lmark    = w_o_end & out_wrote_q;
   wire [OPW-1:0]  w_o_used   = wp_o_q - rp_o_q;
   wire            w_out_room = (w_o_used < OUT_LIM);
   wire            w_nak_room = (w_o_used < NAK_LIM);
   wire            w_pop      = sl_arb_grant & sl_data_next & (rp_o_q != cp_o_q);

   assign sl_overflow         = w_match ? ovf_q : 1'bz;
   assign sl_data             = sl_arb_grant ? out_mem_q[rp_o_q[OUT_DEPTH_LOG2-1:0]] : 9'bz;
   assign sl_arb_request      = req_q;
   assign in_frame_data       = in_data_q;
   assign in_frame_data_valid = in_vld_q;
   assign out_overflow        = out_ovf_q;

   always_comb begin
      wp_d       = wp_q;
      cp_d       = cp_q;
      rp_d       = rp_q;
      ovf_d      = ovf_q;
      in_wrote_d = in_wrote_q;
      in_vld_d   = in_vld_q;
      in_data_d  = in_data_q;
      in_we      = 1'b0;
      in_wdata   = 9'h000;
      w_nak_set  = 1'b0;

      if (w_in_byte) begin
         if (w_in_room) begin
            in_we      = 1'b1;
            in_wdata   = {1'b0, ma_data};
            wp_d       = wp_q + 1'b1;
            in_wrote_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end

      if (w_in_end) begin
         ovf_d      = 1'b0;
         in_wrote_d = 1'b0;
         w_nak_set  = ovf_q && NAK_ENABLE;
         if (ovf_q && DROP_ON_OVERFLOW) begin
            wp_d = cp_q;
         end else if (in_wrote_q) begin
            in_we    = 1'b1;
            in_wdata = {1'b1, 7'b0, ovf_q};
            wp_d     = wp_q + 1'b1;
            cp_d     = wp_q + 1'b1;
         end
      end

      // Head register refills from committed entries only.
      if (!in_vld_q || in_frame_data_ready) begin
         if (rp_q != cp_q) begin
            in_vld_d  = 1'b1;
            in_data_d = in_mem_q[rp_q[IN_DEPTH_LOG2-1:0]];
            rp_d      = rp_q + 1'b1;
         end else begin
            in_vld_d = 1'b0;
         end
      end
   end

   always_comb begin
      wp_o_d      = wp_o_q;
      cp_o_d      = cp_o_q;
      rp_o_d      = rp_o_q;
      out_wrote_d = out_wrote_q;
      out_drop_d  = out_drop_q;
      out_ovf_d   = 1'b0;
      nak_d       = nak_q;
      state_d     = state_q;
      out_we      = 1'b0;
      out_wdata   = 9'h000;

      case (state_q)
         S_IDLE: begin
            if (w_ob) begin
               if (w_out_room) begin
                  out_we      = 1'b1;
                  out_wdata   = {1'b0, out_frame_data};
                  wp_o_d      = wp_o_q + 1'b1;
                  out_wrote_d = 1'b1;
               end else begin
                  out_ovf_d  = 1'b1;
                  out_drop_d = 1'b1;
               end
            end
            if (w_lmark) begin
               out_we    = 1'b1;
               out_wdata = {1'b1, 7'b0, out_drop_q};
               wp_o_d    = wp_o_q + 1'b1;
               cp_o_d    = wp_o_q + 1'b1;
            end
            if (nak_q && !out_frame_valid && !w_lmark && w_nak_room) begin
               state_d = S_NAK_DATA;
            end
         end
         S_NAK_DATA: begin
            out_we    = 1'b1;
            out_wdata = {1'b0, NAK_CODE};
            wp_o_d    = wp_o_q + 1'b1;
            state_d   = S_NAK_EOF;
            if (w_ob) begin
               out_ovf_d  = 1'b1;
               out_drop_d = 1'b1;
            end
         end
         S_NAK_EOF: begin
            out_we    = 1'b1;
            out_wdata = 9'h100;
            wp_o_d    = wp_o_q + 1'b1;
            cp_o_d    = wp_o_q + 1'b1;
            nak_d     = 1'b0;
            state_d   = S_IDLE;
            if (w_ob) begin
               out_ovf_d  = 1'b1;
               out_drop_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (w_o_end) begin
         out_wrote_d = 1'b0;
         out_drop_d  = 1'b0;
      end
      // A new overflow arriving as the NAK completes must not be lost.
      if (w_nak_set) nak_d = 1'b1;
      if (w_pop) rp_o_d = rp_o_q + 1'b1;
      req_d = (rp_o_d != cp_o_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q        <= '0;
         cp_q        <= '0;
         rp_q        <= '0;
         wp_o_q      <= '0;
         cp_o_q      <= '0;
         rp_o_q      <= '0;
         m_fv_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_wrote_q  <= 1'b0;
         in_vld_q    <= 1'b0;
         in_data_q   <= 9'h000;
         out_fv_q    <= 1'b0;
         out_wrote_q <= 1'b0;
         out_drop_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         nak_q       <= 1'b0;
         req_q       <= 1'b0;
         state_q     <= S_IDLE;
      end else begin
         wp_q        <= wp_d;
         cp_q        <= cp_d;
         rp_q        <= rp_d;
         wp_o_q      <= wp_o_d;
         cp_o_q      <= cp_o_d;
         rp_o_q      <= rp_o_d;
         m_fv_q      <= w_m_fv;
         ovf_q       <= ovf_d;
         in_wrote_q  <= in_wrote_d;
         in_vld_q    <= in_vld_d;
         in_data_q   <= in_data_d;
         out_fv_q    <= out_frame_valid;
         out_wrote_q <= out_wrote_d;
         out_drop_q  <= out_drop_d;
         out_ovf_q   <= out_ovf_d;
         nak_q       <= nak_d;
         req_q       <= req_d;
         state_q     <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (in_we)  in_mem_q[wp_q[IN_DEPTH_LOG2-1:0]]     <= in_wdata;
      if (out_we) out_mem_q[wp_o_q[OUT_DEPTH_LOG2-1:0]] <= out_wdata;
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_interface_mf.sv
// ============================================================================
// tb_bus_interface_mf: two endpoints (drop / truncate) driven from shared stimulus
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_interface_mf;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ma_data, ma_addr, out_data;
   logic       ma_dv, ma_fv, gnt_a, gnt_b, nxt, rdy, latch, ofv;
   wire        sl_ovf_a, sl_ovf_b;
   wire  [8:0] sl_data_a, sl_data_b;
   logic       req_a, req_b, vld_a, vld_b, oovf_a, oovf_b;
   logic [8:0] data_a, data_b;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic       stored;
   } vec_t;
   vec_t vecs [8];

   logic [8:0] seq4 [5];

   always #5 clk = ~clk;

   bus_interface_mf #(.ADDR(8'h20), .ADDR_MASK(8'hF0), .IN_DEPTH_LOG2(3), .OUT_DEPTH_LOG2(2),
                      .DROP_ON_OVERFLOW(1'b1), .NAK_ENABLE(1'b1), .NAK_CODE(8'h15)) dut_a (
      .clk(clk), .rst(rst), .ma_data(ma_data), .ma_addr(ma_addr), .ma_data_valid(ma_dv),
      .ma_frame_valid(ma_fv), .sl_overflow(sl_ovf_a), .sl_data(sl_data_a),
      .sl_arb_request(req_a), .sl_arb_grant(gnt_a), .sl_data_next(nxt),
      .in_frame_data(data_a), .in_frame_data_valid(vld_a), .in_frame_data_ready(rdy),
      .out_frame_data(out_data), .out_frame_data_latch(latch), .out_frame_valid(ofv),
      .out_overflow(oovf_a));

   bus_interface_mf #(.ADDR(8'h20), .ADDR_MASK(8'hF0), .IN_DEPTH_LOG2(3), .OUT_DEPTH_LOG2(3),
                      .DROP_ON_OVERFLOW(1'b0), .NAK_ENABLE(1'b1), .NAK_CODE(8'h15)) dut_b (
      .clk(clk), .rst(rst), .ma_data(ma_data), .ma_addr(ma_addr), .ma_data_valid(ma_dv),
      .ma_frame_valid(ma_fv), .sl_overflow(sl_ovf_b), .sl_data(sl_data_b),
      .sl_arb_request(req_b), .sl_arb_grant(gnt_b), .sl_data_next(nxt),
      .in_frame_data(data_b), .in_frame_data_valid(vld_b), .in_frame_data_ready(rdy),
      .out_frame_data(out_data), .out_frame_data_latch(latch), .out_frame_valid(ofv),
      .out_overflow(oovf_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; ma_data = 8'h00; ma_addr = 8'h20; ma_dv = 1'b0; ma_fv = 1'b0;
      gnt_a = 1'b0; gnt_b = 1'b0; nxt = 1'b0; rdy = 1'b0;
      out_data = 8'h00; latch = 1'b0; ofv = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic send_frame(input logic [7:0] addr, input int n, input logic [7:0] first,
                             input logic [7:0] step);
      ma_addr = addr;
      ma_fv   = 1'b1;
      for (int i = 0; i < n; i++) begin
         ma_data = first + 8'(i) * step;
         ma_dv   = 1'b1;
         tick();
      end
      ma_dv = 1'b0;
      ma_fv = 1'b0;
      tick();
   endtask

   task automatic expect_in(input bit ca, input bit cb, input logic [8:0] exp, input string nm);
      int t = 0;
      while (((ca && !vld_a) || (cb && !vld_b)) && t < 20) begin
         tick();
         t++;
      end
      if (ca) begin
         check({nm, "_vld_a"}, 32'(vld_a), 32'd1);
         check({nm, "_a"}, 32'(data_a), 32'(exp));
      end
      if (cb) begin
         check({nm, "_vld_b"}, 32'(vld_b), 32'd1);
         check({nm, "_b"}, 32'(data_b), 32'(exp));
      end
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
   endtask

   task automatic pop_out(input bit sel, input logic [8:0] exp, input string nm);
      int t = 0;
      while (!(sel ? req_b : req_a) && t < 20) begin
         tick();
         t++;
      end
      check({nm, "_req"}, 32'(sel ? req_b : req_a), 32'd1);
      if (sel) gnt_b = 1'b1;
      else     gnt_a = 1'b1;
      #2;
      check(nm, 32'(sel ? sl_data_b : sl_data_a), 32'(exp));
      nxt = 1'b1;
      tick();
      nxt   = 1'b0;
      gnt_a = 1'b0;
      gnt_b = 1'b0;
   endtask

   initial begin
      vecs[0] = '{8'h2C, 8'h5A, 1'b1};
      vecs[1] = '{8'h3C, 8'h5A, 1'b0};
      vecs[2] = '{8'h20, 8'h11, 1'b1};
      vecs[3] = '{8'h2F, 8'h22, 1'b1};
      vecs[4] = '{8'h10, 8'h33, 1'b0};
      vecs[5] = '{8'hA0, 8'h44, 1'b0};
      vecs[6] = '{8'h00, 8'h55, 1'b0};
      vecs[7] = '{8'hF2, 8'h66, 1'b0};
      seq4 = '{9'h011, 9'h022, 9'h100, 9'h015, 9'h100};

      // Reset state
      do_reset();
      check("rst_vld_a", 32'(vld_a), 32'd0);
      check("rst_vld_b", 32'(vld_b), 32'd0);
      check("rst_data_a", 32'(data_a), 32'd0);
      check("rst_req_b", 32'(req_b), 32'd0);
      check("rst_oovf_a", 32'(oovf_a), 32'd0);
      check("rst_slovf_b", 32'(sl_ovf_b), 32'd0);

      // Address match table: single-byte frames
      for (int i = 0; i < 8; i++) begin
         do_reset();
         send_frame(vecs[i].addr, 1, vecs[i].data, 8'h00);
         repeat (4) tick();
         check($sformatf("vec%0d_vld_a", i), 32'(vld_a), 32'(vecs[i].stored));
         check($sformatf("vec%0d_vld_b", i), 32'(vld_b), 32'(vecs[i].stored));
         if (vecs[i].stored) begin
            check($sformatf("vec%0d_data_b", i), 32'(data_b), {23'd0, 1'b0, vecs[i].data});
         end
      end

      // Three-byte frame to matching then non-matching address
      do_reset();
      send_frame(8'h2C, 3, 8'hA1, 8'h11);
      expect_in(1'b1, 1'b1, 9'h0A1, "t1_b0");
      expect_in(1'b1, 1'b1, 9'h0B2, "t1_b1");
      expect_in(1'b1, 1'b1, 9'h0C3, "t1_b2");
      expect_in(1'b1, 1'b1, 9'h100, "t1_eof");
      send_frame(8'h3C, 3, 8'hA1, 8'h11);
      repeat (5) tick();
      check("t1_nomatch_vld_a", 32'(vld_a), 32'd0);
      check("t1_nomatch_vld_b", 32'(vld_b), 32'd0);

      // Ten-byte frame into an 8-entry input FIFO: drop (a) versus truncate (b)
      do_reset();
      ma_addr = 8'h20;
      ma_fv   = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         ma_data = 8'h2F + 8'(i);
         ma_dv   = 1'b1;
         tick();
         check($sformatf("t2_ovf_a_%0d", i), 32'(sl_ovf_a), 32'(i >= 7));
         check($sformatf("t2_ovf_b_%0d", i), 32'(sl_ovf_b), 32'(i >= 7));
      end
      ma_dv = 1'b0;
      ma_fv = 1'b0;
      tick();
      check("t2_ovf_clr_a", 32'(sl_ovf_a), 32'd0);
      check("t2_ovf_clr_b", 32'(sl_ovf_b), 32'd0);
      repeat (4) tick();
      check("t2_drop_vld_a", 32'(vld_a), 32'd0);
      for (int i = 0; i < 6; i++) begin
         expect_in(1'b0, 1'b1, {1'b0, 8'h30 + 8'(i)}, $sformatf("t3_b%0d", i));
      end
      expect_in(1'b0, 1'b1, 9'h101, "t3_eof");
      check("t2_drop_still_a", 32'(vld_a), 32'd0);
      pop_out(1'b0, 9'h015, "t2_nak_a");
      pop_out(1'b0, 9'h100, "t2_nakeof_a");
      pop_out(1'b1, 9'h015, "t3_nak_b");
      pop_out(1'b1, 9'h100, "t3_nakeof_b");
      repeat (4) tick();
      check("t2_req_idle_a", 32'(req_a), 32'd0);
      check("t3_req_idle_b", 32'(req_b), 32'd0);

      // Local frame open while an overflow queues a NAK
      do_reset();
      ofv = 1'b1;
      out_data = 8'h11; latch = 1'b1;
      tick();
      out_data = 8'h22;
      tick();
      latch = 1'b0;
      send_frame(8'h20, 10, 8'h40, 8'h01);
      repeat (3) tick();
      check("t4_req_open_b", 32'(req_b), 32'd0);
      ofv = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) pop_out(1'b1, seq4[i], $sformatf("t4_b_%0d", i));
      for (int i = 0; i < 5; i++) pop_out(1'b0, seq4[i], $sformatf("t4_a_%0d", i));
      tick();
      check("t4_req_done_b", 32'(req_b), 32'd0);

      // Local five-byte frame into a 4-entry output FIFO (a) and an 8-entry one (b)
      do_reset();
      ofv = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         out_data = 8'(i);
         latch    = 1'b1;
         tick();
         check($sformatf("t5_oovf_a_%0d", i), 32'(oovf_a), 32'(i >= 3));
         check($sformatf("t5_oovf_b_%0d", i), 32'(oovf_b), 32'd0);
      end
      latch = 1'b0;
      ofv   = 1'b0;
      tick();
      check("t5_oovf_end_a", 32'(oovf_a), 32'd0);
      pop_out(1'b0, 9'h001, "t5_a0");
      pop_out(1'b0, 9'h002, "t5_a1");
      pop_out(1'b0, 9'h101, "t5_aeof");
      for (int i = 1; i <= 5; i++) pop_out(1'b1, {1'b0, 8'(i)}, $sformatf("t5_b%0d", i));
      pop_out(1'b1, 9'h100, "t5_beof");

      // Reset in the middle of a received frame
      do_reset();
      ma_addr = 8'h20; ma_fv = 1'b1; ma_dv = 1'b1;
      ma_data = 8'hE1;
      tick();
      ma_data = 8'hE2;
      tick();
      rst = 1'b1; ma_fv = 1'b0; ma_dv = 1'b0;
      tick();
      rst = 1'b0;
      check("t6_vld_a", 32'(vld_a), 32'd0);
      check("t6_data_b", 32'(data_b), 32'd0);
      check("t6_req_b", 32'(req_b), 32'd0);
      check("t6_slovf_a", 32'(sl_ovf_a), 32'd0);
      repeat (5) tick();
      check("t6_nomark_b", 32'(vld_b), 32'd0);
      send_frame(8'h20, 2, 8'h77, 8'h11);
      expect_in(1'b1, 1'b1, 9'h077, "t6_b0");
      expect_in(1'b1, 1'b1, 9'h088, "t6_b1");
      expect_in(1'b1, 1'b1, 9'h100, "t6_eof");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
